// File: rtl/fifo_32_to_8.sv
// Word-to-byte unpacking FIFO: a DEPTH x 32 circular word store feeding a
// one-word output stage that presents bytes LSB-first with first-word-fall-through.
module fifo_32_to_8 #(
   parameter int DEPTH = 1024
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   WRITE,
   input  logic [31:0]            DATA_IN,
   output logic                   FULL,
   input  logic                   READ,
   output logic [7:0]             DATA_OUT,
   output logic                   EMPTY,
   output logic [$clog2(DEPTH):0] SIZE,
   output logic                   OVERFLOW
);

   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

   // Word storage
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;

   // Output stage
   logic [31:0]   out_word;
   logic [1:0]    byte_idx;
   logic          out_valid;
   logic          overflow_q;

   logic          full;
   logic          accept;
   logic          consume;
   logic          stage_free;
   logic          load;
   logic [AW:0]   cnt_next;

   // Every decision below uses registered state only, so a pop never frees
   // room for a write in the same cycle and a fresh write never loads at once.
   always_comb begin
      full       = (cnt == DEPTH_CNT);
      accept     = WRITE && !full;
      consume    = READ && out_valid;
      stage_free = !out_valid || (consume && (byte_idx == 2'd3));
      load       = stage_free && (cnt != '0);
      cnt_next   = cnt + (AW+1)'(accept) - (AW+1)'(load);
   end

   // NOTE: storage arrays carry no reset; clearing them would block RAM
   // inference and stale contents are unreachable once the pointers reset.
   always_ff @(posedge CLK) begin
      if (accept) begin
         mem[wp] <= DATA_IN;
      end
   end

   // Asynchronous read captured at the load edge, so the word appears on
   // DATA_OUT the cycle after the load without an extra pipeline bubble.
   always_ff @(posedge CLK) begin
      if (load) begin
         out_word <= mem[rp];
      end
   end

   // NOTE: all state registers use non-blocking assignments so every
   // process samples the pre-edge values, matching the hardware.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wp         <= '0;
         rp         <= '0;
         cnt        <= '0;
         byte_idx   <= 2'd0;
         out_valid  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         cnt <= cnt_next;
         if (accept) begin
            wp <= wp + 1'b1;
         end
         if (WRITE && full) begin
            overflow_q <= 1'b1;
         end
         if (load) begin
            rp        <= rp + 1'b1;
            byte_idx  <= 2'd0;
            out_valid <= 1'b1;
         end else if (consume) begin
            if (byte_idx == 2'd3) begin
               out_valid <= 1'b0;
            end else begin
               byte_idx <= byte_idx + 2'd1;
            end
         end
      end
   end

   assign FULL     = full;
   assign SIZE     = cnt;
   assign EMPTY    = !out_valid;
   assign OVERFLOW = overflow_q;
   assign DATA_OUT = out_word[{byte_idx, 3'b000} +: 8];

endmodule
